// File: rtl/ahb_map_pkg.sv
// Address map and shared types for the M0 SoC AHB-Lite interconnect.
// Slots above the populated entries use a zero mask with an all-ones base,
// so they can never produce a decode hit.
package ahb_map_pkg;

   localparam int MAX_SLAVES = 16;

   localparam logic [31:0] MAP_BASE [MAX_SLAVES] = '{
      0:       32'h0000_0000,
      1:       32'h4000_0000,
      2:       32'h5000_0000,
      default: 32'hFFFF_FFFF
   };

   localparam logic [31:0] MAP_MASK [MAX_SLAVES] = '{
      0:       32'hF000_0000,
      1:       32'hF000_0000,
      2:       32'hF000_0000,
      default: 32'h0000_0000
   };

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // NONSEQ and SEQ are the only transfer types that demand a real response.
   function automatic logic isActiveTrans(input logic [1:0] htrans);
      return htrans[1];
   endfunction

endpackage

// File: rtl/ahb_interconnect_param_if.sv
// Bundle of master-side and slave-side AHB-Lite signals seen by the interconnect.
// The slave modport is the interconnect's view; master is the view of whoever
// drives the master address phase and the slave responses.
interface ahb_interconnect_param_if #(
   parameter int NUM_SLAVES = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0]            HADDR;
   logic [1:0]                       HTRANS;
   logic [NUM_SLAVES-1:0]            HSEL_SIGNALS;
   logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_SIGNALS;
   logic [NUM_SLAVES-1:0]            HREADYOUT_SIGNALS;
   logic [NUM_SLAVES-1:0]            HRESP_SIGNALS;
   logic [DATA_WIDTH-1:0]            HRDATA;
   logic                             HREADY;
   logic                             HRESP;
   logic [ADDR_WIDTH-1:0]            ERR_ADDR;

   modport master (
      output HADDR, HTRANS, HRDATA_SIGNALS, HREADYOUT_SIGNALS, HRESP_SIGNALS,
      input  HSEL_SIGNALS, HRDATA, HREADY, HRESP, ERR_ADDR
   );

   modport slave (
      input  HADDR, HTRANS, HRDATA_SIGNALS, HREADYOUT_SIGNALS, HRESP_SIGNALS,
      output HSEL_SIGNALS, HRDATA, HREADY, HRESP, ERR_ADDR
   );

endinterface

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers unmapped NONSEQ/SEQ transfers with the
// two-cycle AHB ERROR response and remembers the faulting address.
module ahb_default_slave
   import ahb_map_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  launch_i,
   input  logic [ADDR_WIDTH-1:0] haddr_i,
   output logic                  hready_o,
   output logic                  hresp_o,
   output logic [ADDR_WIDTH-1:0] errAddr_o
);

   ds_state_t             state_q, state_d;
   logic [ADDR_WIDTH-1:0] errAddr_q, errAddr_d;

   // State and fault-address registers, cleared immediately on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= DS_IDLE;
         errAddr_q <= '0;
      end else begin
         state_q   <= state_d;
         errAddr_q <= errAddr_d;
      end
   end

   // Next state: ERR1 always moves to ERR2; IDLE and ERR2 start a new error when launched.
   always_comb begin
      state_d   = state_q;
      errAddr_d = errAddr_q;
      unique case (state_q)
         DS_IDLE, DS_ERR2: begin
            if (launch_i) begin
               state_d   = DS_ERR1;
               errAddr_d = haddr_i;
            end else begin
               state_d = DS_IDLE;
            end
         end
         DS_ERR1: state_d = DS_ERR2;
         default: state_d = DS_IDLE;
      endcase
   end

   // Outputs depend on state only, so the launch path never loops back through HREADY.
   assign hready_o  = (state_q != DS_ERR1);
   assign hresp_o   = (state_q != DS_IDLE);
   assign errAddr_o = errAddr_q;

endmodule

// File: rtl/ahb_interconnect_param.sv
// AHB-Lite interconnect: priority address decoder, data-phase select register
// and response multiplexer for NUM_SLAVES slaves plus a default error slave.
module ahb_interconnect_param
   import ahb_map_pkg::*;
#(
   parameter int NUM_SLAVES = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   ahb_interconnect_param_if.slave bus
);

   localparam int SEL_W = NUM_SLAVES + 1;
   localparam logic [SEL_W-1:0] SEL_RESET = {1'b1, {NUM_SLAVES{1'b0}}};

   logic [NUM_SLAVES-1:0] hit;
   logic [NUM_SLAVES-1:0] decodeSel;
   logic                  decodeDefault;
   logic                  found;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic                  launch;
   logic                  dsReady;
   logic                  dsResp;
   logic [ADDR_WIDTH-1:0] errAddr;
   logic [DATA_WIDTH-1:0] hrdataMux;
   logic                  hreadyMux;
   logic                  hrespMux;

   // Per-slave address match against the map table.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         hit[i] = ((bus.HADDR & ADDR_WIDTH'(MAP_MASK[i])) == ADDR_WIDTH'(MAP_BASE[i]));
      end
   end

   // Lowest-index hit wins so the select stays one-hot even for overlapping entries.
   always_comb begin
      decodeSel = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (hit[i] && !found) begin
            decodeSel[i] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   assign decodeDefault    = ~|hit;
   assign bus.HSEL_SIGNALS = decodeSel;

   // Data-phase select follows the address phase only when the bus is ready.
   always_comb begin
      sel_d = sel_q;
      if (hreadyMux) begin
         sel_d = {decodeDefault, decodeSel};
      end
   end

   // Data-phase select register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sel_q <= SEL_RESET;
      end else begin
         sel_q <= sel_d;
      end
   end

   assign launch = hreadyMux & decodeDefault & isActiveTrans(bus.HTRANS);

   ahb_default_slave #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_defaultSlave (
      .clk       (HCLK),
      .rst_n     (HRESETn),
      .launch_i  (launch),
      .haddr_i   (bus.HADDR),
      .hready_o  (dsReady),
      .hresp_o   (dsResp),
      .errAddr_o (errAddr)
   );

   // Route the data-phase owner's data, ready and response back to the master.
   always_comb begin
      hrdataMux = '0;
      hreadyMux = 1'b1;
      hrespMux  = 1'b0;
      if (sel_q[NUM_SLAVES]) begin
         hreadyMux = dsReady;
         hrespMux  = dsResp;
      end
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) begin
            hrdataMux = bus.HRDATA_SIGNALS[i*DATA_WIDTH +: DATA_WIDTH];
            hreadyMux = bus.HREADYOUT_SIGNALS[i];
            hrespMux  = bus.HRESP_SIGNALS[i];
         end
      end
   end

   assign bus.HRDATA   = hrdataMux;
   assign bus.HREADY   = hreadyMux;
   assign bus.HRESP    = hrespMux;
   assign bus.ERR_ADDR = errAddr;

endmodule

// File: tb/tb_ahb_interconnect_param.sv
// Directed bench for the AHB-Lite interconnect: a three-slave build driven
// through mapped, stalled and unmapped transfers, plus a one-slave build.
module tb_ahb_interconnect_param;
   import ahb_map_pkg::*;

   logic HCLK;
   logic HRESETn;
   int   assertCount;
   int   failCount;

   localparam logic [31:0] RAM_DATA = 32'h1111_0000;
   localparam logic [31:0] SW_DATA  = 32'h0000_A5A5;
   localparam logic [31:0] PIX_DATA = 32'h2222_0000;
   localparam logic [31:0] ONE_DATA = 32'h1357_9BDF;

   ahb_interconnect_param_if #(.NUM_SLAVES(3), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
   ahb_interconnect_param_if #(.NUM_SLAVES(1), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

   ahb_interconnect_param #(.NUM_SLAVES(3), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   ahb_interconnect_param #(.NUM_SLAVES(1), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut1 (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus1)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans);
      bus.HADDR  = addr;
      bus.HTRANS = trans;
   endtask

   task automatic nextCycle();
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;

      HRESETn                = 1'b0;
      bus.HRDATA_SIGNALS     = {PIX_DATA, SW_DATA, RAM_DATA};
      bus.HREADYOUT_SIGNALS  = 3'b111;
      bus.HRESP_SIGNALS      = 3'b000;
      applyStimulus(32'h0000_0010, HTRANS_IDLE);
      bus1.HADDR             = 32'h0000_0000;
      bus1.HTRANS            = HTRANS_IDLE;
      bus1.HRDATA_SIGNALS    = ONE_DATA;
      bus1.HREADYOUT_SIGNALS = 1'b1;
      bus1.HRESP_SIGNALS     = 1'b0;

      // Reset state
      #3;
      checkOutput("rst_hsel",    64'(bus.HSEL_SIGNALS), 64'h1);
      checkOutput("rst_hready",  64'(bus.HREADY),       64'h1);
      checkOutput("rst_hresp",   64'(bus.HRESP),        64'h0);
      checkOutput("rst_hrdata",  64'(bus.HRDATA),       64'h0);
      checkOutput("rst_erraddr", 64'(bus.ERR_ADDR),     64'h0);
      #9 HRESETn = 1'b1;

      // Mapped read from the switches slave
      nextCycle();
      applyStimulus(32'h4000_0000, HTRANS_NONSEQ);
      #1 checkOutput("sw_hsel", 64'(bus.HSEL_SIGNALS), 64'h2);
      nextCycle();
      applyStimulus(32'h0000_0000, HTRANS_IDLE);
      #1;
      checkOutput("sw_hrdata", 64'(bus.HRDATA), 64'(SW_DATA));
      checkOutput("sw_hready", 64'(bus.HREADY), 64'h1);
      checkOutput("sw_hresp",  64'(bus.HRESP),  64'h0);

      // Pixel slave with two wait states, RAM transfer queued behind it
      applyStimulus(32'h5000_0004, HTRANS_NONSEQ);
      nextCycle();
      applyStimulus(32'h0000_0008, HTRANS_NONSEQ);
      bus.HREADYOUT_SIGNALS = 3'b011;
      #1 checkOutput("pix_wait1", 64'(bus.HREADY), 64'h0);
      nextCycle();
      #1;
      checkOutput("pix_wait2",      64'(bus.HREADY),       64'h0);
      checkOutput("pix_wait2_hsel", 64'(bus.HSEL_SIGNALS), 64'h1);
      nextCycle();
      bus.HREADYOUT_SIGNALS = 3'b111;
      #1;
      checkOutput("pix_done_hready", 64'(bus.HREADY), 64'h1);
      checkOutput("pix_done_hrdata", 64'(bus.HRDATA), 64'(PIX_DATA));
      nextCycle();
      applyStimulus(32'h0000_0000, HTRANS_IDLE);
      #1;
      checkOutput("ram_hrdata", 64'(bus.HRDATA), 64'(RAM_DATA));
      checkOutput("ram_hready", 64'(bus.HREADY), 64'h1);

      // Unmapped NONSEQ gets a two-cycle ERROR
      applyStimulus(32'h9000_0000, HTRANS_NONSEQ);
      #1 checkOutput("unm_hsel", 64'(bus.HSEL_SIGNALS), 64'h0);
      nextCycle();
      applyStimulus(32'h0000_0000, HTRANS_IDLE);
      #1;
      checkOutput("err1_hready", 64'(bus.HREADY),   64'h0);
      checkOutput("err1_hresp",  64'(bus.HRESP),    64'h1);
      checkOutput("err1_addr",   64'(bus.ERR_ADDR), 64'h9000_0000);
      checkOutput("err1_hrdata", 64'(bus.HRDATA),   64'h0);
      nextCycle();
      applyStimulus(32'hB000_0000, HTRANS_IDLE);
      #1;
      checkOutput("err2_hready", 64'(bus.HREADY), 64'h1);
      checkOutput("err2_hresp",  64'(bus.HRESP),  64'h1);
      nextCycle();
      #1;
      checkOutput("idle_unm_hready", 64'(bus.HREADY),   64'h1);
      checkOutput("idle_unm_hresp",  64'(bus.HRESP),    64'h0);
      checkOutput("idle_unm_addr",   64'(bus.ERR_ADDR), 64'h9000_0000);

      // Back-to-back unmapped transfers
      applyStimulus(32'h9000_0000, HTRANS_NONSEQ);
      nextCycle();
      applyStimulus(32'hA000_0000, HTRANS_NONSEQ);
      #1;
      checkOutput("b2b_err1a_hready", 64'(bus.HREADY), 64'h0);
      checkOutput("b2b_err1a_hresp",  64'(bus.HRESP),  64'h1);
      nextCycle();
      #1;
      checkOutput("b2b_err2a_hready", 64'(bus.HREADY),   64'h1);
      checkOutput("b2b_err2a_hresp",  64'(bus.HRESP),    64'h1);
      checkOutput("b2b_err2a_addr",   64'(bus.ERR_ADDR), 64'h9000_0000);
      nextCycle();
      applyStimulus(32'h0000_0000, HTRANS_IDLE);
      #1;
      checkOutput("b2b_err1b_hready", 64'(bus.HREADY),   64'h0);
      checkOutput("b2b_err1b_hresp",  64'(bus.HRESP),    64'h1);
      checkOutput("b2b_err1b_addr",   64'(bus.ERR_ADDR), 64'hA000_0000);
      nextCycle();
      #1;
      checkOutput("b2b_err2b_hready", 64'(bus.HREADY), 64'h1);
      checkOutput("b2b_err2b_hresp",  64'(bus.HRESP),  64'h1);
      nextCycle();

      // Asynchronous reset while the error response is in its first cycle
      applyStimulus(32'hC000_0000, HTRANS_NONSEQ);
      nextCycle();
      #1;
      checkOutput("pre_rst_hready", 64'(bus.HREADY),   64'h0);
      checkOutput("pre_rst_addr",   64'(bus.ERR_ADDR), 64'hC000_0000);
      HRESETn = 1'b0;
      #1;
      checkOutput("async_rst_hready", 64'(bus.HREADY),   64'h1);
      checkOutput("async_rst_hresp",  64'(bus.HRESP),    64'h0);
      checkOutput("async_rst_addr",   64'(bus.ERR_ADDR), 64'h0);
      applyStimulus(32'h0000_0000, HTRANS_IDLE);
      #2 HRESETn = 1'b1;

      // Single-slave build decodes only the RAM region
      nextCycle();
      bus1.HADDR  = 32'h4000_0000;
      bus1.HTRANS = HTRANS_NONSEQ;
      #1 checkOutput("one_hsel_sw", 64'(bus1.HSEL_SIGNALS), 64'h0);
      nextCycle();
      bus1.HADDR  = 32'h0000_1234;
      bus1.HTRANS = HTRANS_IDLE;
      #1;
      checkOutput("one_hsel_ram", 64'(bus1.HSEL_SIGNALS), 64'h1);
      checkOutput("one_err1_hready", 64'(bus1.HREADY),   64'h0);
      checkOutput("one_err1_hresp",  64'(bus1.HRESP),    64'h1);
      checkOutput("one_err1_addr",   64'(bus1.ERR_ADDR), 64'h4000_0000);
      nextCycle();
      #1;
      checkOutput("one_err2_hready", 64'(bus1.HREADY), 64'h1);
      checkOutput("one_err2_hresp",  64'(bus1.HRESP),  64'h1);
      nextCycle();
      #1;
      checkOutput("one_ram_hrdata", 64'(bus1.HRDATA), 64'(ONE_DATA));
      checkOutput("one_ram_hresp",  64'(bus1.HRESP),  64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
